// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel edge detector.
// Holds the output mode encodings, kernel weights and the unsigned saturation helper.
package sobel_pkg;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_GX   = 2'd1;
  localparam logic [1:0] MODE_GY   = 2'd2;
  localparam logic [1:0] MODE_MAG  = 2'd3;

  // Sobel kernel weights: outer taps and the doubled middle tap.
  localparam int SOBEL_K_SIDE = 1;
  localparam int SOBEL_K_MID  = 2;

  // Pixels with a coordinate below this have no full 3x3 neighbourhood.
  localparam int BORDER_MIN = 2;

  function automatic logic [31:0] sat_u(input logic [31:0] v, input int unsigned w);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row line store for the Sobel window: o_row1 is the previous line, o_row2 the one before.
// Reads are combinational at i_x; a write pushes row1 down into row2 at the same column.
module sobel_line_buffer #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 11,
  parameter int LINE_W = 1280
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [CNT_W-1:0]  i_x,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_row1,
  output logic [DATA_W-1:0] o_row2
);

  localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  logic [DATA_W-1:0] r_row1 [LINE_W];
  logic [DATA_W-1:0] r_row2 [LINE_W];

  logic          w_in_range;
  logic [AW-1:0] w_addr;

  assign w_in_range = (i_x < CNT_W'(LINE_W));
  assign w_addr     = i_x[AW-1:0];

  // Columns past the line length read as zero and are never stored.
  assign o_row1 = w_in_range ? r_row1[w_addr] : '0;
  assign o_row2 = w_in_range ? r_row2[w_addr] : '0;

  always_ff @(posedge i_clk) begin
    if (i_we && w_in_range) begin
      r_row2[w_addr] <= r_row1[w_addr];
      r_row1[w_addr] <= i_data;
    end
  end

endmodule

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector: pass, |Gx|, |Gy| or magnitude, three-clock latency.
// Define SOBEL_THRESH_EN to binarise modes 1-3 against iTHRESH in the output stage.
module sobel_edge_stream
  import sobel_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int CNT_W     = 11,
  parameter int LINE_W    = 1280,
  parameter int MAG_SHIFT = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [CNT_W-1:0]  iX_Cont,
  input  logic [CNT_W-1:0]  iY_Cont,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [1:0]        iMODE,
  input  logic [DATA_W-1:0] iTHRESH,
  output logic [DATA_W-1:0] oEdge,
  output logic              oDVAL
);

  // iDVAL is a pure valid with no backpressure: every cycle it is high one pixel is
  // consumed, and exactly one oDVAL pulse follows three clocks later, in order.

  localparam int GW = DATA_W + 3;
  localparam int MW = DATA_W + 4;
  localparam logic [GW-1:0]     K_SIDE = GW'(SOBEL_K_SIDE);
  localparam logic [GW-1:0]     K_MID  = GW'(SOBEL_K_MID);
  localparam logic [DATA_W-1:0] MAXV   = '1;

  logic [DATA_W-1:0] w_lb_row1;
  logic [DATA_W-1:0] w_lb_row2;
  logic              w_lb_we;

  assign w_lb_we = iDVAL && !iRST;

  sobel_line_buffer #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .LINE_W (LINE_W)
  ) u_line_buffer (
    .i_clk  (iCLK),
    .i_we   (w_lb_we),
    .i_x    (iX_Cont),
    .i_data (iDATA),
    .o_row1 (w_lb_row1),
    .o_row2 (w_lb_row2)
  );

  // S0: window shift registers, row 0 oldest line, column 2 newest pixel.
  logic [DATA_W-1:0] r_p00, r_p01, r_p02;
  logic [DATA_W-1:0] r_p10, r_p11, r_p12;
  logic [DATA_W-1:0] r_p20, r_p21, r_p22;
  logic              r_s0_vld;
  logic [1:0]        r_s0_mode;
  logic              r_s0_border;
  logic              w_border;

  assign w_border = (iX_Cont < CNT_W'(BORDER_MIN)) ||
                    (iY_Cont < CNT_W'(BORDER_MIN)) ||
                    (iX_Cont >= CNT_W'(LINE_W));

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_p00 <= '0; r_p01 <= '0; r_p02 <= '0;
      r_p10 <= '0; r_p11 <= '0; r_p12 <= '0;
      r_p20 <= '0; r_p21 <= '0; r_p22 <= '0;
      r_s0_vld    <= 1'b0;
      r_s0_mode   <= MODE_PASS;
      r_s0_border <= 1'b0;
    end else begin
      r_s0_vld <= iDVAL;
      if (iDVAL) begin
        r_p00 <= r_p01; r_p01 <= r_p02; r_p02 <= w_lb_row2;
        r_p10 <= r_p11; r_p11 <= r_p12; r_p12 <= w_lb_row1;
        r_p20 <= r_p21; r_p21 <= r_p22; r_p22 <= iDATA;
        r_s0_mode   <= iMODE;
        r_s0_border <= w_border;
      end
    end
  end

  // Gradients in GW bits: the positive and negative sums never exceed 4*(2^DATA_W-1),
  // so the wrapped difference is the exact two's-complement result.
  logic [GW-1:0]        w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic signed [GW-1:0] w_gx, w_gy;

  assign w_gx_pos = K_SIDE * GW'(r_p02) + K_MID * GW'(r_p12) + K_SIDE * GW'(r_p22);
  assign w_gx_neg = K_SIDE * GW'(r_p00) + K_MID * GW'(r_p10) + K_SIDE * GW'(r_p20);
  assign w_gy_pos = K_SIDE * GW'(r_p20) + K_MID * GW'(r_p21) + K_SIDE * GW'(r_p22);
  assign w_gy_neg = K_SIDE * GW'(r_p00) + K_MID * GW'(r_p01) + K_SIDE * GW'(r_p02);
  assign w_gx     = $signed(w_gx_pos - w_gx_neg);
  assign w_gy     = $signed(w_gy_pos - w_gy_neg);

  // S1: registered gradients plus the side-band carried alongside them.
  logic signed [GW-1:0] r_s1_gx, r_s1_gy;
  logic [DATA_W-1:0]    r_s1_p11;
  logic [1:0]           r_s1_mode;
  logic                 r_s1_border;
  logic                 r_s1_vld;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_s1_gx     <= '0;
      r_s1_gy     <= '0;
      r_s1_p11    <= '0;
      r_s1_mode   <= MODE_PASS;
      r_s1_border <= 1'b0;
      r_s1_vld    <= 1'b0;
    end else begin
      r_s1_vld <= r_s0_vld;
      if (r_s0_vld) begin
        r_s1_gx     <= w_gx;
        r_s1_gy     <= w_gy;
        r_s1_p11    <= r_p11;
        r_s1_mode   <= r_s0_mode;
        r_s1_border <= r_s0_border;
      end
    end
  end

  // S2 combinational: absolute values, mode select, saturation.
  logic [GW-1:0]     w_abs_gx, w_abs_gy;
  logic [MW-1:0]     w_mag_sum, w_mag;
  logic [DATA_W-1:0] w_graded;
  logic [DATA_W-1:0] w_result;
  logic              w_thresh_hit;
  logic              w_apply_thresh;

  assign w_abs_gx  = r_s1_gx[GW-1] ? $unsigned(-r_s1_gx) : $unsigned(r_s1_gx);
  assign w_abs_gy  = r_s1_gy[GW-1] ? $unsigned(-r_s1_gy) : $unsigned(r_s1_gy);
  assign w_mag_sum = MW'(w_abs_gx) + MW'(w_abs_gy);
  assign w_mag     = w_mag_sum >> MAG_SHIFT;

  always_comb begin
    w_graded = r_s1_p11;
    case (r_s1_mode)
      MODE_GX:  w_graded = DATA_W'(sat_u(32'(w_abs_gx), DATA_W));
      MODE_GY:  w_graded = DATA_W'(sat_u(32'(w_abs_gy), DATA_W));
      MODE_MAG: w_graded = DATA_W'(sat_u(32'(w_mag), DATA_W));
      default:  w_graded = r_s1_p11;
    endcase
  end

`ifdef SOBEL_THRESH_EN
  assign w_thresh_hit   = (w_graded >= iTHRESH);
  assign w_apply_thresh = (r_s1_mode != MODE_PASS);
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^iTHRESH;
  assign w_thresh_hit    = 1'b0;
  assign w_apply_thresh  = 1'b0;
`endif

  always_comb begin
    w_result = w_graded;
    if (w_apply_thresh) begin
      w_result = w_thresh_hit ? MAXV : '0;
    end
    if (r_s1_border) begin
      w_result = '0;
    end
  end

  // S2: output register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oEdge <= '0;
      oDVAL <= 1'b0;
    end else begin
      oDVAL <= r_s1_vld;
      oEdge <= r_s1_vld ? w_result : '0;
    end
  end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Randomised bench for sobel_edge_stream: frame-level Sobel model feeding an expected queue.
// Build with +define+SOBEL_THRESH_EN to exercise the binarised output path.
module tb_sobel_edge_stream;

  localparam int DATA_W    = 12;
  localparam int CNT_W     = 11;
  localparam int LINE_W    = 8;
  localparam int MAG_SHIFT = 2;
  localparam int MAXV      = (1 << DATA_W) - 1;
  localparam int MAX_ROWS  = 8;

  logic              clk;
  logic              iRST;
  logic [CNT_W-1:0]  iX_Cont;
  logic [CNT_W-1:0]  iY_Cont;
  logic [DATA_W-1:0] iDATA;
  logic              iDVAL;
  logic [1:0]        iMODE;
  logic [DATA_W-1:0] iTHRESH;
  logic [DATA_W-1:0] oEdge;
  logic              oDVAL;

  sobel_edge_stream #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .LINE_W    (LINE_W),
    .MAG_SHIFT (MAG_SHIFT)
  ) dut (
    .iCLK    (clk),
    .iRST    (iRST),
    .iX_Cont (iX_Cont),
    .iY_Cont (iY_Cont),
    .iDATA   (iDATA),
    .iDVAL   (iDVAL),
    .iMODE   (iMODE),
    .iTHRESH (iTHRESH),
    .oEdge   (oEdge),
    .oDVAL   (oDVAL)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int img [MAX_ROWS][LINE_W];
  int n_out, n_nz, n_hit;
  int watch_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: output at input (x,y) is the Sobel result centred on (x-1,y-1).
  function automatic int model(input int x, input int y, input int m, input int th);
    int p[3][3];
    int gx, gy, ax, ay, v;
    if (x < 2 || y < 2 || x >= LINE_W) return 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = img[y-2+r][x-2+c];
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if (m == 0) return p[1][1];
    if (m == 1) v = ax;
    else if (m == 2) v = ay;
    else v = (ax + ay) >> MAG_SHIFT;
    if (v > MAXV) v = MAXV;
`ifdef SOBEL_THRESH_EN
    v = (v >= th) ? MAXV : 0;
`endif
    return v;
  endfunction

  // Hand-derived value seen through the optional binarisation with threshold 200.
  function automatic int pick(input int graded);
`ifdef SOBEL_THRESH_EN
    return (graded >= 200) ? MAXV : 0;
`else
    return graded;
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    if (oDVAL === 1'b1) begin
      n_out++;
      if (oEdge != 0) n_nz++;
      if (int'(oEdge) == watch_val) n_hit++;
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(oDVAL), 0);
      end else begin
        e = exp_q.pop_front();
        check("pix", 32'(oEdge), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      iDVAL   = 1'b0;
      iDATA   = DATA_W'($urandom);
      iX_Cont = CNT_W'($urandom);
      iY_Cont = CNT_W'($urandom);
      iMODE   = 2'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_px(input int x, input int y, input int d, input int m);
    iX_Cont = CNT_W'(x);
    iY_Cont = CNT_W'(y);
    iDATA   = DATA_W'(d);
    iMODE   = 2'(m);
    iDVAL   = 1'b1;
    if (x < LINE_W) img[y][x] = d;
    exp_q.push_back(DATA_W'(model(x, y, m, int'(iTHRESH))));
    @(posedge clk); #1;
    iDVAL = 1'b0;
  endtask

  // kind: 0 flat 100, 1 step 0/400, 2 step 0/4095, 3 random. mode<0 randomises per pixel.
  task automatic run_frame(input int h, input int kind, input int mode, input bit gaps,
                           input bit extra);
    int d, m, xmax;
    for (int y = 0; y < h; y++) begin
      xmax = (extra && $urandom_range(0, 1) == 1) ? LINE_W + 2 : LINE_W;
      for (int x = 0; x < xmax; x++) begin
        case (kind)
          0:       d = 100;
          1:       d = (x < 4) ? 0 : 400;
          2:       d = (x < 4) ? 0 : MAXV;
          default: d = int'($urandom_range(0, MAXV));
        endcase
        m = (mode < 0) ? int'($urandom_range(0, 3)) : mode;
        drive_px(x, y, d, m);
        if (gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    idle(2);
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic clear_counts(input int w);
    n_out = 0; n_nz = 0; n_hit = 0; watch_val = w;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    iRST = 1'b1; iDVAL = 1'b0; iX_Cont = '0; iY_Cont = '0;
    iDATA = '0; iMODE = 2'd0; iTHRESH = DATA_W'(200);
    clear_counts(-1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_dval", 32'(oDVAL), 0);
    check("reset_edge", 32'(oEdge), 0);
    iRST = 1'b0;
    idle(2);

    // Latency: one pixel in, oDVAL three clocks later.
    drive_px(0, 0, 7, 0);
    lat = 1;
    while (oDVAL !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 3);
    drain();

    // Flat frame, magnitude: all zero, one output per input.
    clear_counts(-1);
    run_frame(5, 0, 3, 1'b0, 1'b0);
    drain();
    check("flat_count", 32'(n_out), 40);
    check("flat_nonzero", 32'(n_nz), 0);

    // Vertical step 0/400.
    clear_counts(pick(1600));
    run_frame(5, 1, 1, 1'b0, 1'b0);
    drain();
    check("step_gx_hits", 32'(n_hit), 6);
    check("step_gx_nonzero", 32'(n_nz), 6);

    clear_counts(pick(400));
    run_frame(5, 1, 3, 1'b0, 1'b0);
    drain();
    check("step_mag_hits", 32'(n_hit), 6);

    clear_counts(-1);
    run_frame(5, 1, 2, 1'b0, 1'b0);
    drain();
    check("step_gy_nonzero", 32'(n_nz), 0);

    // Full-scale step saturates |Gx| = 16380 to 4095.
    clear_counts(MAXV);
    run_frame(5, 2, 1, 1'b0, 1'b0);
    drain();
    check("sat_hits", 32'(n_hit), 6);

    // Random frames with gaps, per-pixel mode changes and out-of-line columns.
    for (int f = 0; f < 12; f++) begin
      iTHRESH = DATA_W'($urandom_range(0, MAXV));
      run_frame(int'($urandom_range(3, MAX_ROWS)), 3, -1, f[0], f[1]);
      drain();
    end

    // Reset pulse mid-line, with a pixel offered in the reset cycle.
    iTHRESH = DATA_W'(200);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < LINE_W; x++)
        drive_px(x, y, int'($urandom_range(0, MAXV)), int'($urandom_range(0, 3)));
    for (int x = 0; x < 4; x++)
      drive_px(x, 3, int'($urandom_range(0, MAXV)), 3);
    iRST = 1'b1; iDVAL = 1'b1; iX_Cont = CNT_W'(4); iY_Cont = CNT_W'(3);
    iDATA = DATA_W'($urandom);
    @(posedge clk); #1;
    check("rst_inflight", 32'(exp_q.size()), 2);
    exp_q.delete();
    check("rst_dval", 32'(oDVAL), 0);
    check("rst_edge", 32'(oEdge), 0);
    iRST = 1'b0; iDVAL = 1'b0;
    clear_counts(-1);
    idle(5);
    check("rst_no_out", 32'(n_out), 0);

    // Recovery after reset.
    run_frame(6, 3, -1, 1'b1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
